// File: rtl/clock_pkg.sv
// clock_pkg: shared constants and helpers for the programmable clock divider.
//   DIV_WIDTH_DEF     default width of the divide-ratio input and period counter
//   MIN_RATIO         smallest period the divider can produce (one high, one low cycle)
//   DEFAULT_RATIO_DEF ratio in force after reset until the first period start
//   eff_ratio()       clamps a requested ratio to at least MIN_RATIO
package clock_pkg;

  localparam int unsigned DIV_WIDTH_DEF     = 8;
  localparam int unsigned MIN_RATIO         = 2;
  localparam int unsigned DEFAULT_RATIO_DEF = 2;

  // Ratios 0 and 1 cannot form a period with both phases, so they behave as 2.
  function automatic int unsigned eff_ratio(input int unsigned r);
    return (r < MIN_RATIO) ? MIN_RATIO : r;
  endfunction

endpackage

// File: rtl/period_counter.sv
// period_counter: modulo-N counter for the clock divider.
//   i_clk        board clock, rising edge
//   i_reset      synchronous active-high reset, returns counter to pre-start
//   i_enable     advance the counter; when low everything holds
//   i_div_ratio  requested period, sampled only when a new period starts
//   o_start      next edge begins a new period (pre-start exit or wrap)
//   o_cnt_nxt    counter value after the next edge
//   o_ratio_nxt  latched (clamped) ratio after the next edge
module period_counter
  import clock_pkg::*;
#(
  parameter int unsigned DIV_WIDTH     = DIV_WIDTH_DEF,
  parameter int unsigned DEFAULT_RATIO = DEFAULT_RATIO_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_div_ratio,
  output logic                 o_start,
  output logic [DIV_WIDTH-1:0] o_cnt_nxt,
  output logic [DIV_WIDTH-1:0] o_ratio_nxt
);

  localparam logic [DIV_WIDTH-1:0] RstRatio = DIV_WIDTH'(eff_ratio(DEFAULT_RATIO));

  // r_started low is the pre-start state: no period is running yet.
  logic                 r_started;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_ratio;

  logic                 w_started_nxt;
  logic [DIV_WIDTH-1:0] w_ratio_eff;
  logic                 w_last;

  always_comb begin
    w_ratio_eff   = DIV_WIDTH'(eff_ratio(32'(i_div_ratio)));
    w_last        = (r_cnt == (r_ratio - DIV_WIDTH'(1)));
    w_started_nxt = r_started;
    o_start       = 1'b0;
    o_cnt_nxt     = r_cnt;
    o_ratio_nxt   = r_ratio;
    if (i_enable) begin
      if (!r_started || w_last) begin
        // Period start: the only point where a new ratio may take effect.
        o_start       = 1'b1;
        w_started_nxt = 1'b1;
        o_cnt_nxt     = '0;
        o_ratio_nxt   = w_ratio_eff;
      end else begin
        o_cnt_nxt = r_cnt + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_started <= 1'b0;
      r_cnt     <= '0;
      r_ratio   <= RstRatio;
    end else begin
      r_started <= w_started_nxt;
      r_cnt     <= o_cnt_nxt;
      r_ratio   <= o_ratio_nxt;
    end
  end

endmodule

// File: rtl/clock_generator.sv
// clock_generator: synchronous programmable clock divider with rise/fall strobes.
//   clk         board clock, rising edge
//   reset       synchronous active-high reset (priority over enable)
//   enable      low freezes the divider; strobes are forced low
//   div_ratio   requested period of clock in clk cycles (0 and 1 act as 2)
//   clock       registered divided clock, high for floor(N/2) cycles per period
//   rise_pulse  one-cycle strobe on the edge where clock went 0->1
//   fall_pulse  one-cycle strobe on the edge where clock went 1->0
module clock_generator
  import clock_pkg::*;
#(
  parameter int unsigned DIV_WIDTH     = DIV_WIDTH_DEF,
  parameter int unsigned DEFAULT_RATIO = DEFAULT_RATIO_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  output logic                 clock,
  output logic                 rise_pulse,
  output logic                 fall_pulse
);

  logic                 w_start;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_ratio_nxt;
  logic [DIV_WIDTH-1:0] w_high_len;
  logic                 w_clock_nxt;

  logic r_clock;
  logic r_rise;
  logic r_fall;

  period_counter #(
    .DIV_WIDTH    (DIV_WIDTH),
    .DEFAULT_RATIO(DEFAULT_RATIO)
  ) u_period_counter (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_enable   (enable),
    .i_div_ratio(div_ratio),
    .o_start    (w_start),
    .o_cnt_nxt  (w_cnt_nxt),
    .o_ratio_nxt(w_ratio_nxt)
  );

  // Decode from the counter's next state so clock and strobes land on the same
  // edge as the count they describe; the odd extra cycle falls in the low phase.
  always_comb begin
    w_high_len  = w_ratio_nxt >> 1;
    w_clock_nxt = (w_cnt_nxt < w_high_len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clock <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else if (enable) begin
      r_clock <= w_clock_nxt;
      // Every period start is a rise because the high phase is never empty.
      r_rise  <= w_start;
      r_fall  <= r_clock & ~w_clock_nxt;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign clock      = r_clock;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: tb/tb_clock_generator.sv
// tb_clock_generator: directed self-checking bench for clock_generator.
module tb_clock_generator;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] div_ratio;
  logic       clock;
  logic       rise_pulse;
  logic       fall_pulse;

  int checks;
  int errors;

  clock_generator #(
    .DIV_WIDTH    (8),
    .DEFAULT_RATIO(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .div_ratio (div_ratio),
    .clock     (clock),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs changed after this apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; the next step() is edge 0 of a fresh period.
  task automatic reset_dut(input logic [7:0] ratio);
    reset     = 1'b1;
    enable    = 1'b1;
    div_ratio = ratio;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    div_ratio = 8'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({clock, rise_pulse, fall_pulse} !== 3'b000) begin
        errors++;
        $display("FAIL reset cycle %0d: got clk/rise/fall=%b, expected 000", k,
                 {clock, rise_pulse, fall_pulse});
      end
    end
  endtask

  // Released straight out of test_reset with N=2.
  task automatic test_ratio2();
    logic [0:7] e_clk  = 8'b10101010;
    logic [0:7] e_rise = 8'b10101010;
    logic [0:7] e_fall = 8'b01010101;
    div_ratio = 8'd2;
    reset     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({clock, rise_pulse, fall_pulse} !== {e_clk[k], e_rise[k], e_fall[k]}) begin
        errors++;
        $display("FAIL ratio2 edge %0d: got %b, expected %b", k,
                 {clock, rise_pulse, fall_pulse}, {e_clk[k], e_rise[k], e_fall[k]});
      end
    end
  endtask

  task automatic test_ratio5();
    logic [0:9] e_clk  = 10'b1100011000;
    logic [0:9] e_rise = 10'b1000010000;
    logic [0:9] e_fall = 10'b0010000100;
    reset_dut(8'd5);
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({clock, rise_pulse, fall_pulse} !== {e_clk[k], e_rise[k], e_fall[k]}) begin
        errors++;
        $display("FAIL ratio5 edge %0d: got %b, expected %b", k,
                 {clock, rise_pulse, fall_pulse}, {e_clk[k], e_rise[k], e_fall[k]});
      end
    end
  endtask

  // 4 -> 8 after edge 1: current period stays 2/2, the next one is 4/4.
  task automatic test_ratio_change();
    logic [0:12] e_clk  = 13'b1100111100001;
    logic [0:12] e_rise = 13'b1000100000001;
    logic [0:12] e_fall = 13'b0010000010000;
    reset_dut(8'd4);
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 1) div_ratio = 8'd8;
      checks++;
      if ({clock, rise_pulse, fall_pulse} !== {e_clk[k], e_rise[k], e_fall[k]}) begin
        errors++;
        $display("FAIL ratio_change edge %0d: got %b, expected %b", k,
                 {clock, rise_pulse, fall_pulse}, {e_clk[k], e_rise[k], e_fall[k]});
      end
    end
  endtask

  // N=6, enable low for 3 edges right after the rise; high time still 3 enabled edges.
  task automatic test_enable();
    logic [0:10] e_en   = 11'b10001111111;
    logic [0:10] e_clk  = 11'b11111100011;
    logic [0:10] e_rise = 11'b10000000010;
    logic [0:10] e_fall = 11'b00000010000;
    reset_dut(8'd6);
    for (int k = 0; k < 11; k++) begin
      enable = e_en[k];
      step();
      checks++;
      if ({clock, rise_pulse, fall_pulse} !== {e_clk[k], e_rise[k], e_fall[k]}) begin
        errors++;
        $display("FAIL enable edge %0d: got %b, expected %b", k,
                 {clock, rise_pulse, fall_pulse}, {e_clk[k], e_rise[k], e_fall[k]});
      end
    end
    enable = 1'b1;
  endtask

  // Ratios 0 and 1 must look exactly like N=2.
  task automatic test_ratio_low();
    logic [0:5] e_clk  = 6'b101010;
    logic [0:5] e_rise = 6'b101010;
    logic [0:5] e_fall = 6'b010101;
    logic [7:0] r;
    for (int t = 0; t < 2; t++) begin
      r = 8'(t);
      reset_dut(r);
      for (int k = 0; k < 6; k++) begin
        step();
        checks++;
        if ({clock, rise_pulse, fall_pulse} !== {e_clk[k], e_rise[k], e_fall[k]}) begin
          errors++;
          $display("FAIL ratio_low r=%0d edge %0d: got %b, expected %b", t, k,
                   {clock, rise_pulse, fall_pulse}, {e_clk[k], e_rise[k], e_fall[k]});
        end
      end
    end
  endtask

  // N=8, reset (with enable low, reset must still win) at edge 3 in the high phase.
  task automatic test_reset_mid();
    logic [0:12] e_rst  = 13'b0001000000000;
    logic [0:12] e_en   = 13'b1110111111111;
    logic [0:12] e_clk  = 13'b1110111100001;
    logic [0:12] e_rise = 13'b1000100000001;
    logic [0:12] e_fall = 13'b0000000010000;
    reset_dut(8'd8);
    for (int k = 0; k < 13; k++) begin
      reset  = e_rst[k];
      enable = e_en[k];
      step();
      checks++;
      if ({clock, rise_pulse, fall_pulse} !== {e_clk[k], e_rise[k], e_fall[k]}) begin
        errors++;
        $display("FAIL reset_mid edge %0d: got %b, expected %b", k,
                 {clock, rise_pulse, fall_pulse}, {e_clk[k], e_rise[k], e_fall[k]});
      end
    end
    reset  = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    div_ratio = 8'd0;
    #1;
    test_reset();
    test_ratio2();
    test_ratio5();
    test_ratio_change();
    test_enable();
    test_ratio_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_generator.md
# clock_generator

Synchronous programmable clock divider that derives the processor's pipeline clock from the board clock. It produces a registered divided clock plus single-cycle rise/fall strobes so downstream logic can use clock-enables instead of the derived clock where preferred. It sits at the top of the pipeline processor and feeds instruction memory, register file and pipeline stages.

## Interface
- DIV_WIDTH, default 8: width of the divide-ratio input and internal counter.
- DEFAULT_RATIO, default 2: ratio used after reset until the first load.

Ports:
- clk  input  1: board clock; all logic on rising edge.
- reset  input  1: synchronous, active-high reset.
- enable  input  1: when low, divider freezes.
- div_ratio  input  DIV_WIDTH: requested period of `clock` in `clk` cycles.
- clock  output  1: divided clock, registered.
- rise_pulse  output  1: high for exactly one `clk` cycle when `clock` has just gone 0->1.
- fall_pulse  output  1: high for exactly one `clk` cycle when `clock` has just gone 1->0.

One clock (`clk`); reset is synchronous and active-high.

## Operation
- Effective ratio N = max(div_ratio, 2); values 0 and 1 are treated as 2. `clk` is never passed through combinationally.
- High time H = floor(N/2) `clk` cycles; low time L = N - H cycles. Even N gives 50% duty; odd N gives the extra cycle in the low phase.
- Internal counter `cnt` runs 0..N-1. `clock` is 1 while `cnt` is in [0, H), else 0.
- Ratio latching:
  - `div_ratio` is sampled only on the edge where `cnt` wraps to 0 (start of a period).
  - Mid-period changes take effect at the next period; no glitch or shortened phase is allowed.
  - After reset, the latched ratio is DEFAULT_RATIO until the first wrap.
- Enable:
  - With `enable` low, `cnt`, `clock` and the latched ratio hold their values.
  - `rise_pulse` and `fall_pulse` are 0 while `enable` is low.
  - Re-asserting `enable` resumes exactly where the divider stopped.
- Reset:
  - Forces `cnt` to "pre-start": `clock`=0, `rise_pulse`=0, `fall_pulse`=0, latched ratio = DEFAULT_RATIO.
  - From pre-start, the first enabled edge sets `cnt`=0, `clock`=1, `rise_pulse`=1 and samples `div_ratio`.
  - Reset mid-period aborts the period immediately, with no completion of the current phase.
  - Reset has priority over `enable`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency from reset release (with `enable`=1) to the first `clock` rise: 1 `clk` edge.
- `rise_pulse` and `clock` change on the same edge; `fall_pulse` likewise on the falling transition.
- Steady state:
  - One `rise_pulse` and one `fall_pulse` per N enabled cycles.
  - `fall_pulse` is H cycles after `rise_pulse`.
- A ratio change seen at a wrap edge applies to the period beginning on that edge.

## Structure
- Shared package `clock_pkg`:
  - DIV_WIDTH default.
  - MIN_RATIO = 2.
  - DEFAULT_RATIO.
  - Helper function `eff_ratio(r)` implementing the max(r, 2) clamp.
- Optional sub-module `period_counter`: modulo-N counter with enable, wrap flag and ratio latch.
- The top level derives `clock` and the pulses from the `period_counter` outputs.

## Test plan
- Reset held 3 cycles, then released with `enable`=1 and `div_ratio`=2 -> `clock` toggles every `clk` cycle starting high on the first edge; `rise_pulse` every 2 cycles.
- `div_ratio`=5 -> `clock` high 2 cycles, low 3 cycles; pulses 2 cycles apart within each period, period 5.
- `div_ratio` changed 4 -> 8 in mid-period -> the current period completes with 2 high / 2 low; the next period is 4 high / 4 low.
- `enable` dropped for 3 cycles during a high phase with N=6 -> `clock` stays 1, pulses stay 0; after re-enable the remaining high cycles complete and the total high time is still 3.
- `div_ratio`=0 and `div_ratio`=1 -> behaviour identical to N=2.
- Reset asserted mid-high-phase with N=8 -> on the next edge `clock`=0 and pulses are 0; after release, `clock` rises on the first edge and the period restarts.
